serial_alu_seq: RTL
===================

# serial_alu_seq

Bit-serial sequencer that sits directly upstream of the 1-bit ALU and also consumes its results. It accepts a WIDTH-bit operation (op, a, b) over a valid/ready handshake and drives the 1-bit ALU one bit per cycle, LSB first. It chains carry/borrow across bits itself, because the 1-bit ALU has no carry-in. It returns the WIDTH-bit result plus a final carry/borrow flag over a second valid/ready handshake.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  sequencer idle and able to accept a request.
- in_op  in  2  00 add, 01 sub (a-b), 10 OR, 11 AND.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- alu_op  out  2  op code to the 1-bit ALU.
- alu_a  out  1  current bit of a to the ALU.
- alu_b  out  1  current bit of b to the ALU.
- alu_out  in  1  ALU result bit; combinational return in the same cycle.
- alu_d  in  1  ALU carry/borrow bit; combinational return in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  assembled result.
- out_flag  out  1  final carry (add) or borrow (sub); 0 for OR/AND.

## Operation
- FSM states and transitions:
  - IDLE -> RUN on in_valid & in_ready.
  - RUN -> DONE after WIDTH bit-cycles.
  - DONE -> IDLE on out_valid & out_ready.
- in_ready = (state==IDLE) & ~rst. out_valid = (state==DONE).
- Accept: latch in_op into alu_op; load in_a and in_b into shift registers; clear bit counter, chain bit c, and the result register.
- RUN, bit index i = 0..WIDTH-1:
  - alu_a = a[i], alu_b = b[i].
  - add: r = alu_out ^ c; c_next = alu_d | (alu_out & c).
  - sub: r = alu_out ^ c; c_next = alu_d | (~alu_out & c).
  - OR/AND: r = alu_out; c held at 0.
- Result register shifts right with r entering at the MSB, so bit i lands at out_result[i] after WIDTH shifts.
- DONE: out_flag = c. out_result and out_flag stay stable until the handshake completes.
- alu_a/alu_b are 0 outside RUN. alu_op holds the last latched op.
- Reset values: state IDLE; alu_op 00; alu_a, alu_b, out_valid, out_flag 0; out_result 0; c 0; counter 0.
- Reset during RUN or DONE: the operation is discarded and no out_valid is produced.
- Requests arriving while in_ready=0 are ignored. The upstream block must hold them.
- Wrap-around: add and sub are modulo 2^WIDTH, and overflow is reported only through out_flag.

## Timing
- Request accepted at edge T0 means RUN covers cycles T0+1 .. T0+WIDTH.
- Bit i is presented in cycle T0+1+i and its result is captured at the end of that cycle.
- out_valid rises in cycle T0+WIDTH+1, so accept-to-valid latency is WIDTH+1 cycles.
- out_valid & out_ready at edge T1 means in_ready is high in cycle T1+1. Throughput is one op per WIDTH+2 cycles when out_ready is held high.
- No overlap: in_ready stays low for the whole of RUN and DONE.

## Configuration
- SERIAL_ALU_SEQ_ZERO_FLAG_EN defined: adds output out_zero (1 bit), which is valid with out_valid.
  - out_zero = 1 when out_result == 0. It is computed incrementally during RUN (sticky OR of r bits).
  - out_zero resets to 0.
- Macro not defined: port and logic are absent; all other behaviour is identical.

## Structure
- Shared package serial_alu_pkg:
  - op constants OP_ADD, OP_SUB, OP_OR, OP_AND (2-bit);
  - state enum IDLE/RUN/DONE;
  - chain-update function taking (op, alu_out, alu_d, c) and returning (r, c_next).
- One sub-module: serial_alu_shreg, a parallel-load, right-shift register of width WIDTH, used for a and b.
- The 1-bit ALU is instantiated alongside in the enclosing level, not inside this block. The bench wires a behavioural model of it.

## Test plan
- WIDTH=8, add 0xFF + 0x01 -> out_result 0x00, out_flag 1, out_valid 9 cycles after accept.
- Sub 0x05 - 0x07 -> out_result 0xFE, out_flag 1. Sub 0x07 - 0x05 -> 0x02, flag 0.
- OR 0xA0 | 0x0F -> 0xAF, flag 0. AND 0xF0 & 0x3C -> 0x30, flag 0.
- Hold out_ready=0 for 5 cycles after out_valid:
  - result and flag stay stable;
  - in_ready stays 0;
  - a new in_valid is not accepted until the cycle after the handshake.
- Assert rst in cycle T0+4 of an add -> all outputs at reset values next cycle; no out_valid; a following request 0x12 + 0x34 returns 0x46.
- With SERIAL_ALU_SEQ_ZERO_FLAG_EN: sub 0x3C - 0x3C -> out_result 0x00, out_zero 1, out_flag 0.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: op codes, FSM states and
// the per-bit carry/borrow chain update.
package serial_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic r;
        logic c_next;
    } chain_t;

    // The 1-bit ALU has no carry-in, so the incoming chain bit is folded in here.
    function automatic chain_t chain_step(input logic [1:0] op, input logic alu_out,
                                          input logic alu_d, input logic c);
        chain_t s;
        s.r      = alu_out ^ c;
        s.c_next = 1'b0;
        case (op)
            OP_ADD:  s.c_next = alu_d | (alu_out & c);
            OP_SUB:  s.c_next = alu_d | (~alu_out & c);
            default: s.r      = alu_out;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/serial_alu_seq_if.sv
// Request/response handshake bundle for serial_alu_seq.
// SERIAL_ALU_SEQ_ZERO_FLAG_EN adds the out_zero response signal.
interface serial_alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_flag;
`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
    logic             out_zero;
`endif

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
        output out_zero,
`endif
        output in_ready, out_valid, out_result, out_flag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
        input  out_zero,
`endif
        input  in_ready, out_valid, out_result, out_flag
    );

endinterface

// File: rtl/serial_alu_shreg.sv
// Parallel-load, right-shift operand register; exposes the bit currently at the LSB.
module serial_alu_shreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_shift) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign o_lsb = r_q[0];

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU, LSB first, with carry chaining.
// SERIAL_ALU_SEQ_ZERO_FLAG_EN adds out_zero (result == 0) on the response side.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_alu_seq_if.slave  bus,
    output logic [1:0]       alu_op,
    output logic             alu_a,
    output logic             alu_b,
    input  logic             alu_out,
    input  logic             alu_d
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           r_state;
    state_e           w_next;
    logic [1:0]       r_op;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_a_bit;
    logic             w_b_bit;
    chain_t           w_step;

    assign bus.in_ready = (r_state == IDLE) & ~rst;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_run        = (r_state == RUN);
    assign w_last       = (r_cnt == CW'(WIDTH - 1));
    assign w_step       = chain_step(r_op, alu_out, alu_d, r_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    serial_alu_shreg #(.WIDTH(WIDTH)) u_shreg_a (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_run),
        .i_d     (bus.in_a),
        .o_lsb   (w_a_bit)
    );

    serial_alu_shreg #(.WIDTH(WIDTH)) u_shreg_b (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_run),
        .i_d     (bus.in_b),
        .o_lsb   (w_b_bit)
    );

    // Result enters at the MSB so bit i settles at position i after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_ADD;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= bus.in_op;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_run) begin
            r_result <= {w_step.r, r_result[WIDTH-1:1]};
            r_c      <= w_step.c_next;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

`ifdef SERIAL_ALU_SEQ_ZERO_FLAG_EN
    logic r_nz;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_nz <= 1'b0;
        end else if (w_run) begin
            r_nz <= r_nz | w_step.r;
        end
    end

    assign bus.out_zero = (r_state == DONE) & ~r_nz;
`endif

    assign alu_op         = r_op;
    assign alu_a          = w_run & w_a_bit;
    assign alu_b          = w_run & w_b_bit;
    assign bus.out_valid  = (r_state == DONE);
    assign bus.out_result = r_result;
    assign bus.out_flag   = (r_state == DONE) & r_c;

endmodule
